// File: rtl/dcache_fsab_postbuf_if.sv
// FSAB request channel between the DCache, the posting buffer and the arbiter.
// The master drives the request fields and the slave returns credit pulses.
`ifndef FSAB_DEFINES
`define FSAB_DEFINES
`define FSAB_REQ_HI 0
`define FSAB_DID_HI 4
`define FSAB_ADDR_HI 30
`define FSAB_LEN_HI 3
`define FSAB_DATA_HI 63
`define FSAB_MASK_HI 7
`define FSAB_READ 1'b0
`define FSAB_WRITE 1'b1
`define FSAB_INITIAL_CREDITS 4
`endif

interface dcache_fsab_postbuf_if;
    logic                    valid;
    logic [`FSAB_REQ_HI:0]   mode;
    logic [`FSAB_DID_HI:0]   did;
    logic [`FSAB_DID_HI:0]   subdid;
    logic [`FSAB_ADDR_HI:0]  addr;
    logic [`FSAB_LEN_HI:0]   len;
    logic [`FSAB_DATA_HI:0]  data;
    logic [`FSAB_MASK_HI:0]  mask;
    logic                    credit;

    modport master (output valid, mode, did, subdid, addr, len, data, mask, input credit);
    modport slave  (input valid, mode, did, subdid, addr, len, data, mask, output credit);
endinterface

// File: rtl/dcache_fsab_postbuf.sv
// In-order posting buffer between the DCache FSAB port and the FSAB arbiter.
// Define POSTBUF_COALESCE_EN to merge back-to-back single-beat writes to the same address.
`ifndef FSAB_DEFINES
`define FSAB_DEFINES
`define FSAB_REQ_HI 0
`define FSAB_DID_HI 4
`define FSAB_ADDR_HI 30
`define FSAB_LEN_HI 3
`define FSAB_DATA_HI 63
`define FSAB_MASK_HI 7
`define FSAB_READ 1'b0
`define FSAB_WRITE 1'b1
`define FSAB_INITIAL_CREDITS 4
`endif

module dcache_fsab_postbuf #(
    parameter int DEPTH        = 4,
    parameter int DEPTH_LOG2   = 2,
    parameter int UP_CREDITS   = `FSAB_INITIAL_CREDITS,
    parameter int DOWN_CREDITS = `FSAB_INITIAL_CREDITS
) (
    input  logic                  clk,
    input  logic                  rst,
    dcache_fsab_postbuf_if.slave  dc__fsabo,
    dcache_fsab_postbuf_if.master fsabo,
    output logic                  postbuf_empty,
    output logic                  postbuf_err
);
    localparam int DCW    = $clog2(DOWN_CREDITS + 1);
    localparam int CW     = DEPTH_LOG2 + 1;
    // A buffer shallower than the DCache's credit pool could be overrun by legal traffic.
    localparam bit CFG_OK = (DEPTH >= UP_CREDITS) && (DEPTH <= (1 << DEPTH_LOG2));

    logic [`FSAB_REQ_HI:0]  mem_mode   [DEPTH];
    logic [`FSAB_DID_HI:0]  mem_did    [DEPTH];
    logic [`FSAB_DID_HI:0]  mem_subdid [DEPTH];
    logic [`FSAB_ADDR_HI:0] mem_addr   [DEPTH];
    logic [`FSAB_LEN_HI:0]  mem_len    [DEPTH];
    logic [`FSAB_DATA_HI:0] mem_data   [DEPTH];
    logic [`FSAB_MASK_HI:0] mem_mask   [DEPTH];

    logic [DEPTH_LOG2-1:0] head;
    logic [DEPTH_LOG2-1:0] tail;
    logic [CW-1:0]         count;
    logic [DCW-1:0]        down_credits;
    logic [CW-1:0]         pending_up;
    logic [CW-1:0]         up_next;
    logic                  full;
    logic                  issue;
    logic                  merge;
    logic                  push;
    logic                  drop;
    logic                  credit_sat;

    function automatic logic [DEPTH_LOG2-1:0] ptr_inc(input logic [DEPTH_LOG2-1:0] p);
        return (p == DEPTH_LOG2'(DEPTH - 1)) ? '0 : p + DEPTH_LOG2'(1);
    endfunction

`ifdef POSTBUF_COALESCE_EN
    logic [DEPTH_LOG2-1:0] tail_last;
    assign tail_last = (tail == '0) ? DEPTH_LOG2'(DEPTH - 1) : tail - DEPTH_LOG2'(1);
`endif

    always_comb begin
        postbuf_empty = (count == '0);
        full          = (count == CW'(DEPTH));
        issue         = !postbuf_empty && (down_credits != '0);
`ifdef POSTBUF_COALESCE_EN
        // The tail is only leaving this cycle when it is also the head being issued.
        merge = dc__fsabo.valid && (dc__fsabo.mode == `FSAB_WRITE)
                && (dc__fsabo.len == (`FSAB_LEN_HI + 1)'(1)) && !postbuf_empty
                && (mem_mode[tail_last] == `FSAB_WRITE)
                && (mem_len[tail_last] == (`FSAB_LEN_HI + 1)'(1))
                && (mem_addr[tail_last] == dc__fsabo.addr)
                && (mem_did[tail_last] == dc__fsabo.did)
                && (mem_subdid[tail_last] == dc__fsabo.subdid)
                && !(issue && (count == CW'(1)));
`else
        merge = 1'b0;
`endif
        push       = dc__fsabo.valid && !merge && (!full || issue);
        drop       = dc__fsabo.valid && !merge && full && !issue;
        credit_sat = fsabo.credit && !issue && (down_credits == DCW'(DOWN_CREDITS));
        up_next    = pending_up + CW'(issue) + CW'(merge);
    end

    always_comb begin
        fsabo.valid  = issue;
        fsabo.mode   = issue ? mem_mode[head]   : 'x;
        fsabo.did    = issue ? mem_did[head]    : 'x;
        fsabo.subdid = issue ? mem_subdid[head] : 'x;
        fsabo.addr   = issue ? mem_addr[head]   : 'x;
        fsabo.len    = issue ? mem_len[head]    : 'x;
        fsabo.data   = issue ? mem_data[head]   : 'x;
        fsabo.mask   = issue ? mem_mask[head]   : 'x;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_mode[tail]   <= dc__fsabo.mode;
            mem_did[tail]    <= dc__fsabo.did;
            mem_subdid[tail] <= dc__fsabo.subdid;
            mem_addr[tail]   <= dc__fsabo.addr;
            mem_len[tail]    <= dc__fsabo.len;
            mem_data[tail]   <= dc__fsabo.data;
            mem_mask[tail]   <= dc__fsabo.mask;
        end
`ifdef POSTBUF_COALESCE_EN
        else if (merge) begin
            for (int b = 0; b <= `FSAB_MASK_HI; b++) begin
                if (dc__fsabo.mask[b]) begin
                    mem_data[tail_last][8*b +: 8] <= dc__fsabo.data[8*b +: 8];
                end
            end
            mem_mask[tail_last] <= mem_mask[tail_last] | dc__fsabo.mask;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            down_credits    <= DCW'(DOWN_CREDITS);
            pending_up      <= '0;
            dc__fsabo.credit <= 1'b0;
            postbuf_err     <= 1'b0;
        end else begin
            if (push) begin
                tail <= ptr_inc(tail);
            end
            if (issue) begin
                head <= ptr_inc(head);
            end
            case ({push, issue})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (fsabo.credit && !issue) begin
                if (down_credits != DCW'(DOWN_CREDITS)) begin
                    down_credits <= down_credits + DCW'(1);
                end
            end else if (!fsabo.credit && issue) begin
                down_credits <= down_credits - DCW'(1);
            end

            // One credit pulse per cycle; any surplus waits in pending_up.
            dc__fsabo.credit <= (up_next != '0);
            pending_up       <= up_next - CW'(up_next != '0);

            if (drop || credit_sat || !CFG_OK) begin
                postbuf_err <= 1'b1;
            end
        end
    end
endmodule
